spi_reg_bank_burst: RTL

- Parametrised successor to the single-access SPI register-bank path.
- SPI slave supporting all four CPOL/CPHA modes, with the mode latched per frame. Each frame carries one 8-bit command (R/W + address) followed by an unbounded burst of REG_WIDTH-bit data words, with the address auto-incrementing.
- Sits behind the existing 2-stage synchronizers; all SPI inputs are already synchronous to clk.
- Exposes a flat rw register bank, a flat ro status input bank, and a write strobe for downstream logic.

---
 rtl/spi_reg_bank_burst.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank_burst.sv
// SPI slave register bank: one command byte then an unbounded burst of data words
// with region-wrapping address auto-increment, all four CPOL/CPHA modes.
module spi_reg_bank_burst #(
  parameter int unsigned          NUM_CFG    = 8,
  parameter int unsigned          NUM_STATUS = 8,
  parameter int unsigned          REG_WIDTH  = 8,
  parameter logic [REG_WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs,
  output logic                            wr_strobe,
  output logic [6:0]                      wr_addr
);

  localparam int unsigned RX_W   = (REG_WIDTH > 8) ? REG_WIDTH : 8;
  localparam int unsigned CNT_W  = $clog2(RX_W);
  localparam int unsigned BANK_W = NUM_CFG * REG_WIDTH;
  localparam logic [7:0]  CFG_END = 8'(NUM_CFG);
  localparam logic [7:0]  RO_END  = 8'(NUM_CFG + NUM_STATUS);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(REG_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RX_W-1:0]        rx_q, rx_d;
  logic [REG_WIDTH-1:0]   tx_q, tx_d;
  logic [6:0]             addr_q, addr_d;
  logic                   write_q, write_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   abort_q, abort_d;
  logic                   sclk_q, sclk_d;
  logic                   miso_q, miso_d;
  logic [BANK_W-1:0]      rw_q, rw_d;
  logic                   strobe_q, strobe_d;
  logic [6:0]             wr_addr_q, wr_addr_d;

  logic                   lead, trail, sample, shift;
  logic [RX_W-1:0]        rx_next;
  logic [6:0]             load_addr;
  logic [REG_WIDTH-1:0]   load_word;

  function automatic logic in_rw(input logic [6:0] a);
    return {1'b0, a} < CFG_END;
  endfunction

  function automatic logic in_ro(input logic [6:0] a);
    return ({1'b0, a} >= CFG_END) && ({1'b0, a} < RO_END);
  endfunction

  // Increment wraps inside the start region; invalid addresses stay put.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    logic [6:0] n;
    n = a;
    if (in_rw(a))      n = ({1'b0, a} == CFG_END - 8'd1) ? 7'd0 : a + 7'd1;
    else if (in_ro(a)) n = ({1'b0, a} == RO_END - 8'd1) ? CFG_END[6:0] : a + 7'd1;
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    write_d   = write_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    abort_d   = abort_q;
    sclk_d    = spi_clk;
    miso_d    = miso_q;
    rw_d      = rw_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;

    lead    = (sclk_q != spi_clk) && (spi_clk != cpol_q);
    trail   = (sclk_q != spi_clk) && (spi_clk == cpol_q);
    sample  = cpha_q ? trail : lead;
    // cpha=0 keeps the freshly loaded MSB through the first trailing edge of a word
    shift   = cpha_q ? lead : (trail && (cnt_q != '0));
    rx_next = {rx_q[RX_W-2:0], spi_mosi};

    load_addr = (state_q == ST_CMD) ? rx_next[6:0] : next_addr(addr_q);
    load_word = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if ({1'b0, load_addr} == 8'(k)) load_word = rw_q[k*REG_WIDTH +: REG_WIDTH];
    for (int k = 0; k < NUM_STATUS; k++)
      if ({1'b0, load_addr} == 8'(NUM_CFG + k)) load_word = ro_regs[k*REG_WIDTH +: REG_WIDTH];

    if (spi_cs_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      abort_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!abort_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            cpol_d  = mode[1];
            cpha_d  = mode[0];
          end
        end
        ST_CMD: begin
          if (sample) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CMD_LAST) begin
              state_d = ST_DATA;
              cnt_d   = '0;
              write_d = rx_next[7];
              addr_d  = rx_next[6:0];
              if (!rx_next[7]) begin
                tx_d = load_word;
                if (!cpha_q) begin
                  miso_d = load_word[REG_WIDTH-1];
                  tx_d   = load_word << 1;
                end
              end
            end
          end
        end
        ST_DATA: begin
          if (shift && !write_q) begin
            miso_d = tx_q[REG_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (sample) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == WORD_LAST) begin
              cnt_d  = '0;
              addr_d = next_addr(addr_q);
              if (write_q && in_rw(addr_q)) begin
                for (int k = 0; k < NUM_CFG; k++)
                  if ({1'b0, addr_q} == 8'(k)) rw_d[k*REG_WIDTH +: REG_WIDTH] = rx_next[REG_WIDTH-1:0];
                strobe_d  = 1'b1;
                wr_addr_d = addr_q;
              end
              if (!write_q) begin
                tx_d = load_word;
                if (!cpha_q) begin
                  miso_d = load_word[REG_WIDTH-1];
                  tx_d   = load_word << 1;
                end
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset leaves abort set so a frame interrupted by reset is ignored until CS rises.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      abort_q   <= 1'b1;
      sclk_q    <= 1'b0;
      miso_q    <= 1'b0;
      rw_q      <= {NUM_CFG{CFG_RESET}};
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      abort_q   <= abort_d;
      sclk_q    <= sclk_d;
      miso_q    <= miso_d;
      rw_q      <= rw_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign spi_miso  = miso_q;
  assign rw_regs   = rw_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule
